sequence_generator_fsm: RTL and testbench

Bit-serial pattern transmitter: the drive side for the team's serial sequence detectors. It captures a parallel pattern and length on a start request, then shifts the pattern out MSB-first, one bit per clock, with a valid strobe. It can repeat the frame with idle gaps between repeats, and pulses done when it finishes. It serves both as a stimulus source in detector benches and as a serial frame transmitter in the design.

---
 rtl/sequence_generator_fsm_if.sv | 28 ++
 rtl/sequence_generator_fsm.sv | 150 +++++++++++++++
 tb/tb_sequence_generator_fsm.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sequence_generator_fsm_if.sv
// Handshake/data bundle for the bit-serial sequence generator.
// master drives the request side; slave is the generator itself.
interface sequence_generator_fsm_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned REP_W = 3
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [REP_W-1:0] repeats;
  logic             abort;
  logic             out;
  logic             valid;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, pattern, len, repeats, abort,
    input  out, valid, busy, done, err
  );

  modport slave (
    input  start, pattern, len, repeats, abort,
    output out, valid, busy, done, err
  );
endinterface

// File: rtl/sequence_generator_fsm.sv
// Bit-serial pattern transmitter: captures a pattern/length on start and shifts it
// out MSB-first with a valid strobe, optionally repeating with idle gaps in between.
module sequence_generator_fsm #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned REP_W = 3,
  parameter int unsigned GAP   = 2
) (
  input logic                   clk,
  input logic                   rst,
  sequence_generator_fsm_if.slave bus
);

  localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StGap, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pat_q;    // pattern left-aligned so bit len-1 sits at the MSB
  logic [WIDTH-1:0] sh_q;     // working copy; MSB is the bit currently on out
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;
  logic [REP_W-1:0] rep_q;
  logic [GapW-1:0]  gap_q;
  logic             out_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic             len_ok;
  logic [WIDTH-1:0] aligned;
  logic             last_bit;
  logic             gap_last;

  // Request qualification and left-alignment of the incoming pattern.
  always_comb begin
    len_ok   = (bus.len != '0) && (bus.len <= LEN_W'(WIDTH));
    aligned  = bus.pattern << (LEN_W'(WIDTH) - bus.len);
    last_bit = (idx_q == len_q - LEN_W'(1));
    gap_last = (gap_q == GapW'(GAP - 1));
  end

  // Single-process FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      pat_q   <= '0;
      sh_q    <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          out_q   <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          // abort wins over a coincident start
          if (bus.start && !bus.abort) begin
            if (len_ok) begin
              pat_q   <= aligned;
              sh_q    <= aligned;
              len_q   <= bus.len;
              rep_q   <= bus.repeats;
              idx_q   <= '0;
              out_q   <= aligned[WIDTH-1];
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= StShift;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StShift: begin
          if (bus.abort) begin
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (last_bit) begin
            idx_q <= '0;
            if (rep_q == '0) begin
              out_q   <= 1'b0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              rep_q <= rep_q - REP_W'(1);
              if (GAP != 0) begin
                gap_q   <= '0;
                out_q   <= 1'b0;
                valid_q <= 1'b0;
                state_q <= StGap;
              end else begin
                // back-to-back frames: reload without a bubble
                sh_q    <= pat_q;
                out_q   <= pat_q[WIDTH-1];
                valid_q <= 1'b1;
              end
            end
          end else begin
            idx_q <= idx_q + LEN_W'(1);
            sh_q  <= sh_q << 1;
            out_q <= sh_q[WIDTH-2];
          end
        end
        StGap: begin
          if (bus.abort) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (gap_last) begin
            sh_q    <= pat_q;
            out_q   <= pat_q[WIDTH-1];
            valid_q <= 1'b1;
            state_q <= StShift;
          end else begin
            gap_q <= gap_q + GapW'(1);
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          out_q   <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.out   = out_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_sequence_generator_fsm.sv
// Directed bench for sequence_generator_fsm: one GAP=2 instance and one GAP=0 instance.
module tb_sequence_generator_fsm;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  sequence_generator_fsm_if #(.WIDTH(8), .LEN_W(4), .REP_W(3)) bus ();
  sequence_generator_fsm_if #(.WIDTH(8), .LEN_W(4), .REP_W(3)) bus_g0 ();

  sequence_generator_fsm #(.WIDTH(8), .LEN_W(4), .REP_W(3), .GAP(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sequence_generator_fsm #(.WIDTH(8), .LEN_W(4), .REP_W(3), .GAP(0)) u_dut_g0 (
    .clk (clk),
    .rst (rst),
    .bus (bus_g0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame already requested (start=1 set by caller) until busy falls.
  // ov collects {out,valid} pairs for every busy cycle; bits collects valid bits.
  task automatic capture(input bit g0, output logic [63:0] ov, output logic [31:0] bits,
                         output int nbusy, output int nvalid, output int ndone,
                         output int done_at);
    bit   started;
    bit   fin;
    logic o, v, b, d;
    ov = '0; bits = '0; nbusy = 0; nvalid = 0; ndone = 0; done_at = -1;
    started = 1'b0;
    fin = 1'b0;
    for (int c = 0; c < 64 && !fin; c++) begin
      tick();
      bus.start = 1'b0;
      bus_g0.start = 1'b0;
      if (g0) begin
        o = bus_g0.out; v = bus_g0.valid; b = bus_g0.busy; d = bus_g0.done;
      end else begin
        o = bus.out; v = bus.valid; b = bus.busy; d = bus.done;
      end
      if (b) begin
        started = 1'b1;
        nbusy++;
        ov = {ov[61:0], o, v};
        if (v) begin
          bits = {bits[30:0], o};
          nvalid++;
        end
        if (d) begin
          ndone++;
          done_at = nbusy;
        end
      end else if (started) begin
        fin = 1'b1;
      end
    end
    check_eq("frame_end", 64'(fin), 64'd1);
  endtask

  logic [63:0] ov;
  logic [31:0] bits;
  int nbusy, nvalid, ndone, done_at, dcount;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    bus.start = 0; bus.pattern = 0; bus.len = 0; bus.repeats = 0; bus.abort = 0;
    bus_g0.start = 0; bus_g0.pattern = 0; bus_g0.len = 0; bus_g0.repeats = 0; bus_g0.abort = 0;
    tick();
    tick();
    check_eq("rst_out", 64'(bus.out), 64'd0);
    check_eq("rst_valid", 64'(bus.valid), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_err", 64'(bus.err), 64'd0);
    rst = 1'b1;
    tick();

    // Single frame: 101, then done
    bus.pattern = 8'b0000_0101; bus.len = 4'd3; bus.repeats = 3'd0; bus.start = 1'b1;
    capture(1'b0, ov, bits, nbusy, nvalid, ndone, done_at);
    check_eq("t1_ov", ov, 64'b11_01_11_00);
    check_eq("t1_bits", 64'(bits), 64'b101);
    check_eq("t1_nvalid", 64'(nvalid), 64'd3);
    check_eq("t1_nbusy", 64'(nbusy), 64'd4);
    check_eq("t1_ndone", 64'(ndone), 64'd1);
    check_eq("t1_done_at", 64'(done_at), 64'd4);

    // One repeat with a 2-cycle gap
    bus.pattern = 8'b0000_0101; bus.len = 4'd3; bus.repeats = 3'd1; bus.start = 1'b1;
    capture(1'b0, ov, bits, nbusy, nvalid, ndone, done_at);
    check_eq("t2_ov", ov, 64'b11_01_11_00_00_11_01_11_00);
    check_eq("t2_bits", 64'(bits), 64'b101101);
    check_eq("t2_nbusy", 64'(nbusy), 64'd9);
    check_eq("t2_ndone", 64'(ndone), 64'd1);

    // GAP=0: back-to-back frames
    bus_g0.pattern = 8'hA5; bus_g0.len = 4'd8; bus_g0.repeats = 3'd1; bus_g0.start = 1'b1;
    capture(1'b1, ov, bits, nbusy, nvalid, ndone, done_at);
    check_eq("t3_bits", 64'(bits), 64'hA5A5);
    check_eq("t3_nvalid", 64'(nvalid), 64'd16);
    check_eq("t3_nbusy", 64'(nbusy), 64'd17);
    check_eq("t3_done_at", 64'(done_at), 64'd17);

    // len=1 repeated twice, GAP=0
    bus_g0.pattern = 8'h01; bus_g0.len = 4'd1; bus_g0.repeats = 3'd2; bus_g0.start = 1'b1;
    capture(1'b1, ov, bits, nbusy, nvalid, ndone, done_at);
    check_eq("t3b_bits", 64'(bits), 64'b111);
    check_eq("t3b_nbusy", 64'(nbusy), 64'd4);
    check_eq("t3b_ndone", 64'(ndone), 64'd1);

    // Illegal lengths
    bus.pattern = 8'hFF; bus.len = 4'd0; bus.repeats = 3'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("t4_err_len0", 64'(bus.err), 64'd1);
    check_eq("t4_busy_len0", 64'(bus.busy), 64'd0);
    check_eq("t4_valid_len0", 64'(bus.valid), 64'd0);
    tick();
    check_eq("t4_err_clear", 64'(bus.err), 64'd0);
    bus.len = 4'd9; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("t4_err_len9", 64'(bus.err), 64'd1);
    check_eq("t4_busy_len9", 64'(bus.busy), 64'd0);
    tick();
    check_eq("t4_err_clear9", 64'(bus.err), 64'd0);

    // Start ignored mid-frame, then abort at the 2nd bit
    bus.pattern = 8'b1011_0110; bus.len = 4'd8; bus.repeats = 3'd0; bus.start = 1'b1;
    tick();
    check_eq("t5_bit1", 64'({bus.out, bus.valid}), 64'b11);
    bus.pattern = 8'hFF; bus.len = 4'd3;
    tick();
    check_eq("t5_bit2", 64'({bus.out, bus.valid, bus.busy}), 64'b011);
    bus.start = 1'b0; bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("t5_abort", 64'({bus.out, bus.valid, bus.busy}), 64'b000);
    dcount = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.done) dcount++;
      tick();
    end
    check_eq("t5_no_done", 64'(dcount), 64'd0);

    // Asynchronous reset mid-frame, then a fresh frame
    bus.pattern = 8'b0000_0101; bus.len = 4'd3; bus.repeats = 3'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("t6_pre", 64'({bus.out, bus.valid, bus.busy}), 64'b111);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t6_async", 64'({bus.out, bus.valid, bus.busy, bus.done}), 64'b0000);
    tick();
    rst = 1'b1;
    check_eq("t6_held", 64'({bus.valid, bus.busy}), 64'b00);
    tick();
    bus.pattern = 8'b0000_0101; bus.len = 4'd3; bus.repeats = 3'd0; bus.start = 1'b1;
    capture(1'b0, ov, bits, nbusy, nvalid, ndone, done_at);
    check_eq("t6_bits", 64'(bits), 64'b101);
    check_eq("t6_nbusy", 64'(nbusy), 64'd4);
    check_eq("t6_ndone", 64'(ndone), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
